// File: rtl/instruction_fetch_if.sv
// Instruction-memory handshake: one request outstanding over req/gnt, with the response returned on rvalid/rdata.
interface instruction_fetch_if;
    logic        req;
    logic [15:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instruction_fetch.sv
// PC owner and single-outstanding instruction fetcher feeding instruction_decoder.
// Holds the fetched word in ir and slices it into the decoder's fields; ir=16'hF000 acts as a bubble.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        imem,
    input  logic                       stall_i,
    input  logic                       branch_taken_i,
    input  logic [15:0]                branch_target_i,
    input  logic                       flush_i,
    input  logic [15:0]                flush_pc_i,
    output logic                       instr_valid,
    output logic [15:0]                pc_o,
    output logic [3:0]                 opcode,
    output logic [2:0]                 rd,
    output logic [2:0]                 rs1,
    output logic [2:0]                 rs2,
    output logic [6:0]                 immediate,
    output logic [5:0]                 nzimm,
    output logic [8:0]                 offset,
    output logic                       fetch_err
);

    localparam logic [1:0]  REQ   = 2'd0;
    localparam logic [1:0]  WAIT  = 2'd1;
    localparam logic [1:0]  ISSUE = 2'd2;
    localparam logic [1:0]  DRAIN = 2'd3;

    localparam logic [15:0] BUBBLE       = 16'hF000;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state, state_next;
    logic [15:0] pc, pc_next;
    logic [15:0] ir, ir_next;
    logic [7:0]  wait_cnt;
    logic        waiting, waiting_next;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        case (state)
            REQ: begin
                if (flush_i) begin
                    pc_next = flush_pc_i;
                    ir_next = BUBBLE;
                    // A granted request must still have its response drained.
                    if (imem.gnt) state_next = DRAIN;
                end else if (imem.gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    pc_next    = flush_pc_i;
                    ir_next    = BUBBLE;
                    state_next = imem.rvalid ? REQ : DRAIN;
                end else if (imem.rvalid) begin
                    ir_next    = imem.rdata;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    pc_next    = flush_pc_i;
                    ir_next    = BUBBLE;
                    state_next = REQ;
                end else if (!stall_i) begin
                    pc_next    = branch_taken_i ? branch_target_i : pc + 16'd2;
                    ir_next    = BUBBLE;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    pc_next = flush_pc_i;
                    ir_next = BUBBLE;
                end else if (imem.rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    assign waiting      = (state == WAIT) || (state == DRAIN);
    assign waiting_next = (state_next == WAIT) || (state_next == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            ir        <= BUBBLE;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            // Counter saturates so a very long stall cannot wrap it.
            if (waiting && waiting_next)
                wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (waiting && !imem.rvalid && (wait_cnt == TIMEOUT_LAST))
                fetch_err <= 1'b1;
        end
    end

    assign imem.req    = (state == REQ);
    assign imem.addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign pc_o        = pc;
    assign opcode      = ir[15:12];
    assign rd          = ir[11:9];
    assign rs1         = ir[8:6];
    assign rs2         = ir[5:3];
    assign immediate   = ir[6:0];
    assign nzimm       = ir[5:0];
    assign offset      = ir[8:0];

endmodule
